// File: rtl/z_core_reg_file.sv
// Integer register file for the Z-Core RV32I CPU.
// x0 is hardwired to zero and has no storage. x1..x31 are flops with an
// asynchronous, active-high clear. Writes happen on the rising clock edge.
// The two read ports are purely combinational. A read and a write to the
// same index in one cycle are not forwarded: the read shows the old value
// until the edge.
module z_core_reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] rd_in,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   output logic [DATA_WIDTH-1:0] rs1_out,
   output logic [DATA_WIDTH-1:0] rs2_out
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   // Storage starts at index 1 because x0 has no flops. Every read of
   // x0 takes the default zero in the read muxes below.
   logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

   // Write decode: copy current contents, then overlay rd_in on the addressed register.
   always_comb begin
      // NOTE: the default copy comes first so every element of regs_d is
      // assigned on every path. Without it this block would infer latches.
      regs_d = regs_q;
      if (write_enable) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            // rd == 0 matches no entry, so the write to x0 is dropped here.
            if (rd == ADDR_WIDTH'(i)) begin
               regs_d[i] = rd_in;
            end
         end
      end
   end

   // Register storage: asynchronous clear overrides any write in the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: this array is cleared on reset on purpose. Outputs must
         // never show X, even for registers that were never written. For
         // that reason it is built from flops, not an inferred RAM macro.
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments.
         // Readers in this time step then see the pre-edge value, which
         // matches flop behaviour.
         regs_q <= regs_d;
      end
   end

   // Read port 1: combinational mux, x0 falls through to the zero default.
   always_comb begin
      rs1_out = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rs1 == ADDR_WIDTH'(i)) begin
            rs1_out = regs_q[i];
         end
      end
   end

   // Read port 2: independent copy of the port 1 mux.
   always_comb begin
      rs2_out = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rs2 == ADDR_WIDTH'(i)) begin
            rs2_out = regs_q[i];
         end
      end
   end

endmodule

// File: tb/tb_z_core_reg_file.sv
// Self-checking bench for z_core_reg_file.
// The stimulus process drives the ports and keeps a plain array model of
// the 32 registers. For every read it pushes the expected pair into a
// queue and signals the monitor. The monitor pops each entry and compares
// it against the read ports.
module tb_z_core_reg_file;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic          write_enable;
   logic [AW-1:0] rd;
   logic [DW-1:0] rd_in;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [DW-1:0] rs1_out;
   logic [DW-1:0] rs2_out;

   z_core_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .rd           (rd),
      .rd_in        (rd_in),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_out      (rs1_out),
      .rs2_out      (rs2_out)
   );

   typedef struct {
      string       name;
      logic [DW-1:0] exp1;
      logic [DW-1:0] exp2;
   } exp_t;

   exp_t          exp_q [$];
   event          sample_ev;
   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] model [32];

   // 10-unit clock. Inputs change on the falling edge, well away from the rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: on every sample request, pop the oldest expectation and compare both ports.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL monitor: sample with empty expectation queue");
         end else begin
            e = exp_q.pop_front();
            total++;
            if (rs1_out !== e.exp1) begin
               bad++;
               $display("FAIL %s rs1_out: got %h expected %h (rs1=%0d)", e.name, rs1_out, e.exp1, rs1);
            end
            total++;
            if (rs2_out !== e.exp2) begin
               bad++;
               $display("FAIL %s rs2_out: got %h expected %h (rs2=%0d)", e.name, rs2_out, e.exp2, rs2);
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Register-file semantics: clearing resets every entry, and x0 is never written.
   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Set the read addresses, let combinational logic settle, then hand the expectation over.
   task automatic check_read(input int a, input int b, input string name);
      exp_t e;
      rs1 = AW'(a);
      rs2 = AW'(b);
      #1;
      e.name = name;
      e.exp1 = model[a];
      e.exp2 = model[b];
      exp_q.push_back(e);
      ->sample_ev;
      #1;
   endtask

   // One full clock: rising edge (model commits the write if legal), then back to the falling edge.
   task automatic cycle();
      @(posedge clk);
      if (!reset && write_enable && rd != '0) model[rd] = rd_in;
      @(negedge clk);
   endtask

   task automatic set_write(input logic we, input int idx, input logic [DW-1:0] data);
      write_enable = we;
      rd           = AW'(idx);
      rd_in        = data;
   endtask

   initial begin
      int            a, b, w;
      logic [DW-1:0] d;

      reset = 1'b1;
      set_write(1'b0, 0, '0);
      rs1 = '0;
      rs2 = '0;
      model_clear();

      // Reset held: a write attempt across an edge is ignored and reads are 0.
      @(negedge clk);
      set_write(1'b1, 7, 32'h1234_5678);
      cycle();
      check_read(7, 0, "reset_held");
      set_write(1'b0, 0, '0);
      reset = 1'b0;
      @(negedge clk);

      // Test 1: every index reads 0 after reset.
      for (int i = 0; i < 32; i++) check_read(i, 31 - i, "after_reset");

      // Test 2: two writes, then read both ways without any edge.
      set_write(1'b1, 5, 32'd15);
      cycle();
      set_write(1'b1, 8, 32'd25);
      cycle();
      set_write(1'b0, 0, '0);
      check_read(5, 8, "read_5_8");
      check_read(8, 5, "read_8_5");

      // Test 3: write_enable=0 suppresses the write.
      set_write(1'b0, 10, 32'd30);
      cycle();
      check_read(0, 10, "we0_suppress");

      // Test 4: writes to x0 are discarded.
      set_write(1'b1, 0, 32'd40);
      cycle();
      check_read(0, 0, "x0_immutable");

      // Test 6: both ports at the same index.
      check_read(5, 5, "same_index");

      // Test 5: no forwarding across the write edge, then an async reset between edges.
      set_write(1'b1, 31, 32'hDEAD_BEEF);
      check_read(31, 31, "pre_edge_old");
      cycle();
      set_write(1'b0, 0, '0);
      check_read(31, 5, "post_edge_new");
      #1;
      reset = 1'b1;
      model_clear();
      check_read(31, 5, "async_reset_mid");
      set_write(1'b1, 3, 32'hCAFE_F00D);
      cycle();
      set_write(1'b0, 0, '0);
      reset = 1'b0;
      #1;
      check_read(3, 31, "after_async_reset");
      @(negedge clk);

      // Randomized traffic: a read before each edge (old value) and after it (new value).
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(39) == 0) begin
            reset = 1'b1;
            #1;
            model_clear();
            reset = 1'b0;
            #1;
         end
         w = int'($urandom_range(31));
         d = $urandom();
         set_write(($urandom_range(9) < 7), w, d);
         a = ($urandom_range(2) == 0) ? w : int'($urandom_range(31));
         b = ($urandom_range(2) == 0) ? w : int'($urandom_range(31));
         check_read(a, b, "rnd_pre_edge");
         cycle();
         set_write(1'b0, int'($urandom_range(31)), $urandom());
         check_read(a, b, "rnd_post_edge");
      end

      // Drain the scoreboard with a bounded wait.
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
